// File: rtl/comm_link_sequencer_if.sv
// Modem link bundle between the sequencer and its neighbours.
// master: sequencer side; slave: nibble source, codec, DAC/ADC, sink.
interface comm_link_sequencer_if #(
  parameter int CNT_W = 8
);
  // nibble source handshake
  logic [3:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  // encoder
  logic [3:0]       enc_in;
  logic [7:0]       enc_code;
  // analog path
  logic [7:0]       dac_data;
  logic             dac_wr;
  logic             adc_en;
  logic [7:0]       adc_data;
  // decoder
  logic [7:0]       dec_code;
  logic [3:0]       dec_data;
  logic             dec_err;
  // result handshake and status
  logic [3:0]       out_data;
  logic             out_fail;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    input  in_data, in_valid,
    output in_ready,
    output enc_in,
    input  enc_code,
    output dac_data, dac_wr, adc_en,
    input  adc_data,
    output dec_code,
    input  dec_data, dec_err,
    output out_data, out_fail, out_valid,
    input  out_ready,
    output busy, frame_cnt, err_cnt
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready,
    input  enc_in,
    output enc_code,
    input  dac_data, dac_wr, adc_en,
    output adc_data,
    input  dec_code,
    output dec_data, dec_err,
    input  out_data, out_fail, out_valid,
    output out_ready,
    input  busy, frame_cnt, err_cnt
  );
endinterface

// File: rtl/comm_link_sequencer.sv
// Sequences one nibble through encoder, DAC, ADC and decoder with retry.
// Ports: sys_clk, reset (sync, active-low), bus (comm_link_sequencer_if.master).
module comm_link_sequencer #(
  parameter int ENC_LAT   = 1,
  parameter int DEC_LAT   = 1,
  parameter int SETTLE    = 4,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  comm_link_sequencer_if.master bus
);

  localparam int WMAX0  = (ENC_LAT > DEC_LAT) ? ENC_LAT : DEC_LAT;
  localparam int WMAX   = (WMAX0 > SETTLE) ? WMAX0 : SETTLE;
  localparam int WAIT_W = (WMAX > 1) ? $clog2(WMAX) : 1;
  localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [WAIT_W-1:0] ENC_END = WAIT_W'(ENC_LAT - 1);
  localparam logic [WAIT_W-1:0] DEC_END = WAIT_W'(DEC_LAT - 1);
  localparam logic [WAIT_W-1:0] SET_END =
    WAIT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [RTY_W-1:0]  RTY_MAX = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENCODE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DECODE,
    S_CHECK,
    S_RESULT
  } state_t;

  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait;
  logic [RTY_W-1:0]   r_retry;
  logic               r_in_ready;
  logic [3:0]         r_enc_in;
  logic [7:0]         r_dac_data;
  logic               r_dac_wr;
  logic               r_adc_en;
  logic [7:0]         r_dec_code;
  logic [3:0]         r_out_data;
  logic               r_out_fail;
  logic               r_out_valid;
  logic               r_busy;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic               w_pass;

  // r_enc_in doubles as the held nibble for the check
  assign w_pass = (bus.dec_data == r_enc_in) && !bus.dec_err;

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_retry     <= '0;
      r_in_ready  <= 1'b1;
      r_enc_in    <= '0;
      r_dac_data  <= '0;
      r_dac_wr    <= 1'b0;
      r_adc_en    <= 1'b0;
      r_dec_code  <= '0;
      r_out_data  <= '0;
      r_out_fail  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      // strobes are one-cycle: raised on entry, dropped here
      r_dac_wr <= 1'b0;
      r_adc_en <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_enc_in   <= bus.in_data;
            r_retry    <= '0;
            r_wait     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          if (r_wait == ENC_END) begin
            r_dac_wr <= 1'b1;
            r_state  <= S_DRIVE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DRIVE: begin
          r_dac_data <= bus.enc_code;
          r_wait     <= '0;
          if (SETTLE == 0) begin
            r_adc_en <= 1'b1;
            r_state  <= S_SAMPLE;
          end else begin
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_wait == SET_END) begin
            r_adc_en <= 1'b1;
            r_state  <= S_SAMPLE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_SAMPLE: begin
          r_dec_code <= bus.adc_data;
          r_wait     <= '0;
          r_state    <= S_DECODE;
        end
        S_DECODE: begin
          if (r_wait == DEC_END) begin
            r_state <= S_CHECK;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_CHECK: begin
          if (w_pass) begin
            r_out_data  <= bus.dec_data;
            r_out_fail  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_RESULT;
          end else begin
            if (r_err_cnt != '1) begin
              r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            // retry re-drives the latched code word; encoder not rerun
            if (r_retry < RTY_MAX) begin
              r_retry  <= r_retry + RTY_W'(1);
              r_dac_wr <= 1'b1;
              r_state  <= S_DRIVE;
            end else begin
              r_out_data  <= bus.dec_data;
              r_out_fail  <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_RESULT;
            end
          end
        end
        S_RESULT: begin
          if (bus.out_ready) begin
            if (r_frame_cnt != '1) begin
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.enc_in    = r_enc_in;
  assign bus.dac_data  = r_dac_data;
  assign bus.dac_wr    = r_dac_wr;
  assign bus.adc_en    = r_adc_en;
  assign bus.dec_code  = r_dec_code;
  assign bus.out_data  = r_out_data;
  assign bus.out_fail  = r_out_fail;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_comm_link_sequencer.sv
// Directed bench for comm_link_sequencer.
// Instance a: defaults, 4-cycle analog loop; instance b: CNT_W=2, SETTLE=0.
module tb_comm_link_sequencer;

  logic clk;
  logic reset;

  comm_link_sequencer_if #(.CNT_W(8)) a_if ();
  comm_link_sequencer_if #(.CNT_W(2)) b_if ();

  comm_link_sequencer #(
    .ENC_LAT(1), .DEC_LAT(1), .SETTLE(4),
    .MAX_RETRY(2), .CNT_W(8)
  ) u_a (
    .sys_clk (clk),
    .reset   (reset),
    .bus     (a_if.master)
  );

  comm_link_sequencer #(
    .ENC_LAT(1), .DEC_LAT(1), .SETTLE(0),
    .MAX_RETRY(2), .CNT_W(2)
  ) u_b (
    .sys_clk (clk),
    .reset   (reset),
    .bus     (b_if.master)
  );

  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic       a_inj;
  int         a_inj_at;
  logic       a_err;
  logic       b_err;
  logic [7:0] d1, d2, d3, d4;
  int         a_dac_n, a_adc_n;
  int         b_dac_n, b_adc_n;
  int         cyc, b_dac_cyc, b_adc_cyc;
  int         overlap;

  // code word: parity-ish high nibble, data low nibble
  assign a_if.enc_code = {a_if.enc_in ^ 4'h5, a_if.enc_in};
  assign b_if.enc_code = {b_if.enc_in ^ 4'h5, b_if.enc_in};

  always @(posedge clk) begin
    d1  <= a_if.dac_data;
    d2  <= d1;
    d3  <= d2;
    d4  <= d3;
    cyc <= cyc + 1;
  end

  assign a_if.adc_data = d4;
  assign b_if.adc_data = b_if.dac_data;

  assign a_if.dec_data = (a_inj && a_adc_n == a_inj_at) ?
                         4'h3 : a_if.dec_code[3:0];
  assign a_if.dec_err  = a_err;
  assign b_if.dec_data = b_if.dec_code[3:0];
  assign b_if.dec_err  = b_err;

  always @(negedge clk) begin
    if (a_if.dac_wr) a_dac_n <= a_dac_n + 1;
    if (a_if.adc_en) a_adc_n <= a_adc_n + 1;
    if (b_if.dac_wr) begin
      b_dac_n   <= b_dac_n + 1;
      b_dac_cyc <= cyc;
    end
    if (b_if.adc_en) begin
      b_adc_n   <= b_adc_n + 1;
      b_adc_cyc <= cyc;
    end
    if ((a_if.dac_wr && a_if.adc_en) || (b_if.dac_wr && b_if.adc_en))
      overlap <= overlap + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
  endtask

  task automatic a_xfer(input logic [3:0] nib, output int lat);
    a_if.in_data  = nib;
    a_if.in_valid = 1'b1;
    step();
    a_if.in_valid = 1'b0;
    lat = 0;
    while (!a_if.out_valid && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic b_xfer(input logic [3:0] nib, output int lat);
    b_if.in_data  = nib;
    b_if.in_valid = 1'b1;
    step();
    b_if.in_valid = 1'b0;
    lat = 0;
    while (!b_if.out_valid && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic a_hs();
    a_if.out_ready = 1'b1;
    step();
    a_if.out_ready = 1'b0;
  endtask

  task automatic b_hs();
    b_if.out_ready = 1'b1;
    step();
    b_if.out_ready = 1'b0;
  endtask

  int lat;
  int bd, ba;

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    vectors = 0;
    miscompares = 0;
    a_inj = 1'b0; a_inj_at = 0; a_err = 1'b0; b_err = 1'b0;
    a_dac_n = 0; a_adc_n = 0; b_dac_n = 0; b_adc_n = 0;
    cyc = 0; b_dac_cyc = 0; b_adc_cyc = 0; overlap = 0;
    a_if.in_data = '0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_data = '0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;

    // reset state
    do_reset();
    chk("rst in_ready", a_if.in_ready, 1);
    chk("rst busy", a_if.busy, 0);
    chk("rst out_valid", a_if.out_valid, 0);
    chk("rst out_fail", a_if.out_fail, 0);
    chk("rst out_data", a_if.out_data, 0);
    chk("rst dac_wr", a_if.dac_wr, 0);
    chk("rst adc_en", a_if.adc_en, 0);
    chk("rst dac_data", a_if.dac_data, 0);
    chk("rst dec_code", a_if.dec_code, 0);
    chk("rst enc_in", a_if.enc_in, 0);
    chk("rst frame_cnt", a_if.frame_cnt, 0);
    chk("rst err_cnt", a_if.err_cnt, 0);

    // clean transfer
    bd = a_dac_n; ba = a_adc_n;
    a_xfer(4'hA, lat);
    chk("clean latency", lat, 9);
    chk("clean out_data", a_if.out_data, 4'hA);
    chk("clean out_fail", a_if.out_fail, 0);
    chk("clean enc_in", a_if.enc_in, 4'hA);
    chk("clean dac pulses", a_dac_n - bd, 1);
    chk("clean adc pulses", a_adc_n - ba, 1);
    chk("clean in_ready", a_if.in_ready, 0);
    chk("clean busy", a_if.busy, 1);
    a_hs();
    chk("clean frame_cnt", a_if.frame_cnt, 1);
    chk("clean err_cnt", a_if.err_cnt, 0);
    chk("clean out_valid drop", a_if.out_valid, 0);
    chk("clean in_ready back", a_if.in_ready, 1);
    chk("clean busy drop", a_if.busy, 0);

    // single retry
    do_reset();
    bd = a_dac_n;
    a_inj_at = a_adc_n + 1;
    a_inj = 1'b1;
    a_xfer(4'hA, lat);
    chk("retry latency", lat, 17);
    chk("retry out_data", a_if.out_data, 4'hA);
    chk("retry out_fail", a_if.out_fail, 0);
    chk("retry err_cnt", a_if.err_cnt, 1);
    chk("retry dac pulses", a_dac_n - bd, 2);
    a_hs();
    a_inj = 1'b0;
    chk("retry frame_cnt", a_if.frame_cnt, 1);

    // retries exhausted
    do_reset();
    bd = a_dac_n;
    a_err = 1'b1;
    a_xfer(4'hA, lat);
    chk("exhaust latency", lat, 25);
    chk("exhaust out_fail", a_if.out_fail, 1);
    chk("exhaust out_data", a_if.out_data, 4'hA);
    chk("exhaust err_cnt", a_if.err_cnt, 3);
    chk("exhaust dac pulses", a_dac_n - bd, 3);
    a_hs();
    a_err = 1'b0;
    chk("exhaust frame_cnt", a_if.frame_cnt, 1);

    // backpressure, with in_valid noise that must be ignored
    a_xfer(4'h5, lat);
    chk("bp latency", lat, 9);
    a_if.in_data  = 4'hC;
    a_if.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp out_valid", a_if.out_valid, 1);
      chk("bp out_data", a_if.out_data, 4'h5);
      chk("bp out_fail", a_if.out_fail, 0);
      chk("bp in_ready", a_if.in_ready, 0);
    end
    a_if.in_valid = 1'b0;
    a_hs();
    chk("bp frame_cnt", a_if.frame_cnt, 2);
    chk("bp err_cnt", a_if.err_cnt, 3);

    // reset in SETTLE abandons the transfer
    a_if.in_data  = 4'h6;
    a_if.in_valid = 1'b1;
    step();
    a_if.in_valid = 1'b0;
    step();
    step();
    chk("mid busy", a_if.busy, 1);
    reset = 1'b0;
    step();
    chk("mid rst in_ready", a_if.in_ready, 1);
    chk("mid rst busy", a_if.busy, 0);
    chk("mid rst out_valid", a_if.out_valid, 0);
    chk("mid rst dac_wr", a_if.dac_wr, 0);
    chk("mid rst frame_cnt", a_if.frame_cnt, 0);
    chk("mid rst err_cnt", a_if.err_cnt, 0);
    reset = 1'b1;
    repeat (12) step();
    chk("mid no result", a_if.out_valid, 0);
    chk("mid still idle", a_if.in_ready, 1);

    // SETTLE=0 instance: direct SAMPLE after DRIVE
    b_xfer(4'h9, lat);
    chk("b latency", lat, 5);
    chk("b out_data", b_if.out_data, 4'h9);
    chk("b out_fail", b_if.out_fail, 0);
    chk("b drive->sample gap", b_adc_cyc - b_dac_cyc, 1);
    b_hs();
    chk("b frame 1", b_if.frame_cnt, 1);

    // saturating counters at CNT_W=2
    b_err = 1'b1;
    b_xfer(4'h4, lat);
    chk("b fail latency", lat, 13);
    chk("b fail out_fail", b_if.out_fail, 1);
    chk("b err 3", b_if.err_cnt, 3);
    b_hs();
    b_xfer(4'h4, lat);
    chk("b err saturated", b_if.err_cnt, 3);
    b_hs();
    chk("b frame 3", b_if.frame_cnt, 3);
    b_err = 1'b0;
    b_xfer(4'h2, lat);
    chk("b clean out_data", b_if.out_data, 4'h2);
    b_hs();
    chk("b frame saturated", b_if.frame_cnt, 3);
    chk("b err held", b_if.err_cnt, 3);

    chk("strobe overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
